// File: rtl/crc_rx_pkg.sv
// Shared types, control codes and CRC-32 step functions for the receive FCS checker.
// The optional length check is enabled by defining CRC_RX_LEN_CHECK_EN.
package crc_rx_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CRC_W   = 32;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 1518;

  localparam logic [7:0]       CTRL_SOF  = 8'h09;
  localparam logic [7:0]       CTRL_DATA = 8'h0b;
  localparam logic [7:0]       CTRL_EOF  = 8'h0d;
  localparam logic [CRC_W-1:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_POLY  = 32'h04C1_1DB7;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic crc_ok;
    logic crc_err;
    logic len_err;
    logic frame_abort;
  } status_t;

  // Byte count of a legal end-beat mask; 0 marks an illegal mask.
  function automatic logic [CNT_W-1:0] bvalid_bytes(input logic [7:0] bv);
    logic [CNT_W-1:0] n;
    case (bv)
      8'hff:   n = 4'd8;
      8'hfe:   n = 4'd7;
      8'hfc:   n = 4'd6;
      8'hf8:   n = 4'd5;
      8'hf0:   n = 4'd4;
      8'he0:   n = 4'd3;
      8'hc0:   n = 4'd2;
      8'h80:   n = 4'd1;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] a,
                                               input logic [CNT_W-1:0] n);
    logic [LEN_W:0] s;
    s = (LEN_W+1)'(a) + (LEN_W+1)'(n);
    return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
  endfunction

  // MSB-first CRC-32 over the low nbits of d; nbits is a constant at each call site.
  function automatic logic [CRC_W-1:0] crc32_bits(input logic [DATA_W-1:0] d,
                                                  input int nbits,
                                                  input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      if (i < nbits) begin
        fb = r[31] ^ d[i];
        r  = {r[30:0], 1'b0};
        if (fb) r = r ^ CRC_POLY;
      end
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d8(input logic [7:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 8, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d16(input logic [15:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 16, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d24(input logic [23:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 24, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d32(input logic [31:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 32, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d40(input logic [39:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 40, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d48(input logic [47:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 48, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d56(input logic [55:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(64'(d), 56, c);
  endfunction

  function automatic logic [CRC_W-1:0] crc32_d64(input logic [63:0] d, input logic [CRC_W-1:0] c);
    return crc32_bits(d, 64, c);
  endfunction

endpackage

// File: rtl/crc_rx_check_crc.sv
// crc32_var64: combinational CRC-32 step over the leading 1..8 bytes of a 64-bit beat.
// A byte count of 0 passes the CRC through unchanged.
module crc32_var64
  import crc_rx_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_nbytes,
  input  logic [CRC_W-1:0]  i_crc,
  output logic [CRC_W-1:0]  o_crc_c
);

  // Byte 0 lives in [63:56], so partial beats always use the upper bytes.
  always_comb begin
    o_crc_c = i_crc;
    case (i_nbytes)
      4'd1:    o_crc_c = crc32_d8 (i_data[63:56], i_crc);
      4'd2:    o_crc_c = crc32_d16(i_data[63:48], i_crc);
      4'd3:    o_crc_c = crc32_d24(i_data[63:40], i_crc);
      4'd4:    o_crc_c = crc32_d32(i_data[63:32], i_crc);
      4'd5:    o_crc_c = crc32_d40(i_data[63:24], i_crc);
      4'd6:    o_crc_c = crc32_d48(i_data[63:16], i_crc);
      4'd7:    o_crc_c = crc32_d56(i_data[63:8],  i_crc);
      4'd8:    o_crc_c = crc32_d64(i_data,        i_crc);
      default: o_crc_c = i_crc;
    endcase
  end

endmodule

// File: rtl/crc_rx_check.sv
// crc_rx_check: receive-side FCS checker; forwards beats one cycle late with an aligned status pulse.
// Define CRC_RX_LEN_CHECK_EN to build the frame-length range check driving o_len_err.
module crc_rx_check
  import crc_rx_pkg::*;
#(
  parameter logic [31:0] RESIDUE = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dready,
  input  logic [DATA_W-1:0] i_datain,
  input  logic [7:0]        i_ctrl_wd,
  input  logic [7:0]        i_bvalid,
  output logic              o_data_vld,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_status_vld,
  output logic              o_crc_ok,
  output logic              o_crc_err,
  output logic              o_len_err,
  output logic              o_frame_abort,
  output logic [LEN_W-1:0]  o_frame_len,
  output logic [CRC_W-1:0]  o_crc_out
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   w_crc_nxt;
  logic [CRC_W-1:0]   w_crc_in;
  logic [CRC_W-1:0]   w_crc_step;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [LEN_W-1:0]   w_len_rpt;
  logic [CNT_W-1:0]   w_eof_bytes;
  logic [CNT_W-1:0]   w_nbytes;
  logic               w_sof;
  logic               w_data;
  logic               w_eof;
  logic               w_report;
  logic               w_len_bad;
  status_t            w_flags;
  status_t            w_status;

  logic               r_data_vld;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_status_vld;
  status_t            r_status;
  logic [LEN_W-1:0]   r_frame_len;

  assign w_sof       = i_dready && (i_ctrl_wd == CTRL_SOF);
  assign w_data      = i_dready && (i_ctrl_wd == CTRL_DATA);
  assign w_eof       = i_dready && (i_ctrl_wd == CTRL_EOF);
  assign w_eof_bytes = bvalid_bytes(i_bvalid);

  // A SOF always seeds from the init value, including the abort-and-restart case.
  assign w_crc_in = w_sof ? CRC_INIT : r_crc;
  assign w_nbytes = w_eof ? w_eof_bytes : CNT_W'(8);

  crc32_var64 u_crc (
    .i_data   (i_datain),
    .i_nbytes (w_nbytes),
    .i_crc    (w_crc_in),
    .o_crc_c  (w_crc_step)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_crc   <= CRC_INIT;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_crc   <= w_crc_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_len_nxt   = r_len;
    w_len_rpt   = r_len;
    w_report    = 1'b0;
    w_flags     = '0;
    case (r_state)
      IDLE: begin
        if (w_sof) begin
          w_state_nxt = IN_FRAME;
          w_crc_nxt   = w_crc_step;
          w_len_nxt   = LEN_W'(8);
        end
      end
      IN_FRAME: begin
        if (w_sof) begin
          w_report            = 1'b1;
          w_flags.frame_abort = 1'b1;
          w_len_rpt           = r_len;
          w_crc_nxt           = w_crc_step;
          w_len_nxt           = LEN_W'(8);
        end else if (w_data) begin
          w_crc_nxt = w_crc_step;
          w_len_nxt = len_add(r_len, CNT_W'(8));
        end else if (w_eof) begin
          w_report    = 1'b1;
          w_state_nxt = IDLE;
          w_crc_nxt   = w_crc_step;
          w_len_rpt   = len_add(r_len, w_eof_bytes);
          w_len_nxt   = w_len_rpt;
          // An illegal mask counts no bytes and always reports a CRC error.
          if (w_eof_bytes == '0) begin
            w_flags.crc_err = 1'b1;
          end else begin
            w_flags.crc_ok  = (w_crc_step == RESIDUE);
            w_flags.crc_err = (w_crc_step != RESIDUE);
          end
        end
      end
    endcase
  end

`ifdef CRC_RX_LEN_CHECK_EN
  assign w_len_bad = (w_len_rpt < LEN_W'(MIN_LEN)) || (w_len_rpt > LEN_W'(MAX_LEN));
`else
  assign w_len_bad = 1'b0;
`endif

  assign w_status = status_t'{crc_ok:      w_flags.crc_ok,
                              crc_err:     w_flags.crc_err,
                              len_err:     w_report & w_len_bad,
                              frame_abort: w_flags.frame_abort};

  // Forwarding and status registers; status fields hold between pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_vld   <= 1'b0;
      r_data_out   <= '0;
      r_status_vld <= 1'b0;
      r_status     <= '0;
      r_frame_len  <= '0;
    end else begin
      r_data_vld   <= i_dready;
      r_data_out   <= i_datain;
      r_status_vld <= w_report;
      if (w_report) begin
        r_status    <= w_status;
        r_frame_len <= w_len_rpt;
      end
    end
  end

  assign o_data_vld    = r_data_vld;
  assign o_data_out    = r_data_out;
  assign o_status_vld  = r_status_vld;
  assign o_crc_ok      = r_status.crc_ok;
  assign o_crc_err     = r_status.crc_err;
  assign o_len_err     = r_status.len_err;
  assign o_frame_abort = r_status.frame_abort;
  assign o_frame_len   = r_frame_len;
  assign o_crc_out     = r_crc;

endmodule

// File: tb/tb_crc_rx_check.sv
// Self-checking bench for crc_rx_check: random frames scored by a byte-level CRC model.
module tb_crc_rx_check;

  localparam logic [7:0] SOF  = 8'h09;
  localparam logic [7:0] DATA = 8'h0b;
  localparam logic [7:0] EOF  = 8'h0d;

  logic        clk = 1'b0;
  logic        rst;
  logic        dready;
  logic [63:0] datain;
  logic [7:0]  ctrl_wd;
  logic [7:0]  bvalid;
  logic        data_vld;
  logic [63:0] data_out;
  logic        status_vld;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic        frame_abort;
  logic [15:0] frame_len;
  logic [31:0] crc_out;

  int checks = 0;
  int errors = 0;
  int n_status = 0;
  int n_fwd_bad = 0;

  logic [19:0] caps[$];
  logic [7:0]  frm[$];
  logic [31:0] crc_tab[256];

  crc_rx_check dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_dready      (dready),
    .i_datain      (datain),
    .i_ctrl_wd     (ctrl_wd),
    .i_bvalid      (bvalid),
    .o_data_vld    (data_vld),
    .o_data_out    (data_out),
    .o_status_vld  (status_vld),
    .o_crc_ok      (crc_ok),
    .o_crc_err     (crc_err),
    .o_len_err     (len_err),
    .o_frame_abort (frame_abort),
    .o_frame_len   (frame_len),
    .o_crc_out     (crc_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void build_tab();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      crc_tab[i] = c;
    end
  endfunction

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = (c << 8) ^ crc_tab[c[31:24] ^ frm[i]];
    return c;
  endfunction

  function automatic logic len_bad(input int l);
`ifdef CRC_RX_LEN_CHECK_EN
    return (l < 64) || (l > 1518);
`else
    return (l < 0);
`endif
  endfunction

  function automatic logic [15:0] sat16(input int l);
    return (l > 65535) ? 16'hFFFF : 16'(l);
  endfunction

  // {crc_ok, crc_err, len_err, frame_abort, frame_len} for a completed frame.
  function automatic logic [19:0] exp_frame();
    logic ok;
    ok = (ref_crc() == 32'h0);
    return {ok, ~ok, len_bad(frm.size()), 1'b0, sat16(frm.size())};
  endfunction

  function automatic void make_frame(input int len);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
    fcs = ref_crc();
    frm.push_back(fcs[31:24]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[7:0]);
  endfunction

  // ---------------- stimulus ----------------
  task automatic beat(input logic dr, input logic [7:0] ct, input logic [63:0] d, input logic [7:0] bv);
    dready = dr; ctrl_wd = ct; datain = d; bvalid = bv;
    @(posedge clk); #1;
    if (data_vld !== dr || data_out !== d) n_fwd_bad++;
    if (status_vld === 1'b1) begin
      n_status++;
      caps.push_back({crc_ok, crc_err, len_err, frame_abort, frame_len});
    end
  endtask

  task automatic idle_beat();
    beat(1'b0, 8'($urandom), {$urandom, $urandom}, 8'($urandom));
  endtask

  // Drive frm as beats; nbeats>0 stops early, max_gap>0 inserts 1..max_gap idle cycles.
  task automatic send_frame(input int max_gap, input int nbeats);
    int nb, lim, n;
    logic [63:0] d;
    logic [7:0] ct, bv;
    nb  = (frm.size() + 7) / 8;
    lim = (nbeats > 0 && nbeats < nb) ? nbeats : nb;
    for (int b = 0; b < lim; b++) begin
      if (b > 0 && max_gap > 0) repeat ($urandom_range(max_gap, 1)) idle_beat();
      n = frm.size() - 8 * b;
      if (n > 8) n = 8;
      d = {$urandom, $urandom};
      for (int j = 0; j < n; j++) d[63 - 8*j -: 8] = frm[8*b + j];
      ct = (b == 0) ? SOF : (b == nb - 1) ? EOF : DATA;
      bv = (b == nb - 1) ? 8'(8'hFF << (8 - n)) : 8'($urandom);
      beat(1'b1, ct, d, bv);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    beat(1'b1, SOF, {$urandom, $urandom}, 8'hff);
    beat(1'b1, SOF, {$urandom, $urandom}, 8'hff);
    checks++;
    if (data_vld !== 1'b0 || data_out !== 64'h0) begin
      errors++; $display("FAIL reset_fwd: data_vld=%b data_out=%h, want 0/0", data_vld, data_out);
    end
    checks++;
    if ({status_vld, crc_ok, crc_err, len_err, frame_abort} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, want 00000", {status_vld, crc_ok, crc_err, len_err, frame_abort});
    end
    checks++;
    if (frame_len !== 16'h0) begin
      errors++; $display("FAIL reset_len: got %h, want 0000", frame_len);
    end
    checks++;
    if (crc_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_crc: got %h, want ffffffff", crc_out);
    end
    rst = 1'b0;
    idle_beat();
  endtask

  task automatic test_good_frame();
    logic [19:0] e;
    int s0;
    make_frame(64); e = exp_frame(); s0 = n_status;
    send_frame(0, 0);
    checks++;
    if (status_vld !== 1'b1 || n_status != s0 + 1) begin
      errors++; $display("FAIL good_pulse: status_vld=%b pulses=%0d, want 1/1", status_vld, n_status - s0);
    end
    checks++;
    if (caps[caps.size()-1] !== e) begin
      errors++; $display("FAIL good_status: got %h, want %h", caps[caps.size()-1], e);
    end
    checks++;
    if (crc_out !== 32'h0) begin
      errors++; $display("FAIL good_residue: got %h, want 00000000", crc_out);
    end
    idle_beat();
    checks++;
    if (status_vld !== 1'b0 || {crc_ok, crc_err, len_err, frame_abort, frame_len} !== e) begin
      errors++; $display("FAIL good_hold: vld=%b status=%h, want 0/%h", status_vld,
                         {crc_ok, crc_err, len_err, frame_abort, frame_len}, e);
    end
    // Same frame, bit 0 of byte 10 flipped.
    frm[10] = frm[10] ^ 8'h01; e = exp_frame(); s0 = n_status;
    send_frame(0, 0);
    checks++;
    if (n_status != s0 + 1 || caps[caps.size()-1] !== e || e[19] !== 1'b0) begin
      errors++; $display("FAIL bad_crc: got %h pulses=%0d, want %h", caps[caps.size()-1], n_status - s0, e);
    end
    idle_beat();
  endtask

  task automatic test_short_frame();
    logic [19:0] e;
    int s0;
    make_frame(20); e = exp_frame(); s0 = n_status;
    send_frame(0, 0);
    checks++;
    if (n_status != s0 + 1 || caps[caps.size()-1] !== e) begin
      errors++; $display("FAIL short: got %h pulses=%0d, want %h", caps[caps.size()-1], n_status - s0, e);
    end
    checks++;
    if (bvalid !== 8'hf0) begin
      errors++; $display("FAIL short_mask: drove %h, want f0", bvalid);
    end
    idle_beat();
  endtask

  task automatic test_abort();
    logic [19:0] ea, e;
    int s0;
    s0 = n_status;
    frm.delete();
    for (int i = 0; i < 24; i++) frm.push_back(8'($urandom));
    send_frame(0, 2);
    ea = {1'b0, 1'b0, len_bad(16), 1'b1, 16'd16};
    make_frame(64); e = exp_frame();
    send_frame(0, 0);
    checks++;
    if (n_status != s0 + 2) begin
      errors++; $display("FAIL abort_pulses: got %0d, want 2", n_status - s0);
    end
    checks++;
    if (caps[s0] !== ea) begin
      errors++; $display("FAIL abort_status: got %h, want %h", caps[s0], ea);
    end
    checks++;
    if (caps[s0+1] !== e) begin
      errors++; $display("FAIL abort_next: got %h, want %h", caps[s0+1], e);
    end
    idle_beat();
  endtask

  task automatic test_bad_bvalid();
    logic [19:0] e;
    int s0;
    s0 = n_status;
    beat(1'b1, SOF,  {$urandom, $urandom}, 8'hff);
    beat(1'b1, DATA, {$urandom, $urandom}, 8'hff);
    beat(1'b1, EOF,  {$urandom, $urandom}, 8'h0f);
    e = {1'b0, 1'b1, len_bad(16), 1'b0, 16'd16};
    checks++;
    if (status_vld !== 1'b1 || n_status != s0 + 1 || caps[caps.size()-1] !== e) begin
      errors++; $display("FAIL bad_bvalid: got %h vld=%b, want %h", caps[caps.size()-1], status_vld, e);
    end
    idle_beat();
  endtask

  task automatic test_ignored();
    int s0, f0;
    s0 = n_status; f0 = n_fwd_bad;
    beat(1'b1, DATA,  {$urandom, $urandom}, 8'hff);
    beat(1'b1, EOF,   {$urandom, $urandom}, 8'hff);
    beat(1'b1, 8'h55, {$urandom, $urandom}, 8'hff);
    beat(1'b0, SOF,   {$urandom, $urandom}, 8'hff);
    beat(1'b1, 8'h00, {$urandom, $urandom}, 8'h80);
    checks++;
    if (n_status != s0) begin
      errors++; $display("FAIL ignored_status: got %0d pulses, want 0", n_status - s0);
    end
    checks++;
    if (n_fwd_bad != f0) begin
      errors++; $display("FAIL ignored_fwd: %0d bad forwards, want 0", n_fwd_bad - f0);
    end
  endtask

  task automatic test_stall();
    logic [19:0] e;
    int s0, f0;
    make_frame(64); e = exp_frame(); s0 = n_status; f0 = n_fwd_bad;
    send_frame(3, 0);
    checks++;
    if (status_vld !== 1'b1 || n_status != s0 + 1 || caps[caps.size()-1] !== e) begin
      errors++; $display("FAIL stall_status: got %h pulses=%0d, want %h", caps[caps.size()-1], n_status - s0, e);
    end
    checks++;
    if (n_fwd_bad != f0) begin
      errors++; $display("FAIL stall_fwd: %0d bad forwards, want 0", n_fwd_bad - f0);
    end
    idle_beat();
  endtask

  task automatic test_reset_mid();
    logic [19:0] e;
    int s0;
    make_frame(64); s0 = n_status;
    send_frame(0, 4);
    rst = 1'b1;
    idle_beat();
    idle_beat();
    rst = 1'b0;
    idle_beat();
    checks++;
    if (n_status != s0 || crc_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rst_mid: pulses=%0d crc=%h, want 0/ffffffff", n_status - s0, crc_out);
    end
    make_frame(64); e = exp_frame();
    send_frame(0, 0);
    checks++;
    if (n_status != s0 + 1 || caps[caps.size()-1] !== e || e[19] !== 1'b1) begin
      errors++; $display("FAIL rst_mid_next: got %h, want %h", caps[caps.size()-1], e);
    end
    idle_beat();
  endtask

  task automatic test_back_to_back();
    logic [19:0] eq[$];
    int s0, len;
    s0 = n_status;
    for (int f = 0; f < 16; f++) begin
      len = (f == 5) ? 1600 : int'($urandom_range(200, 9));
      make_frame(len);
      if ($urandom_range(2, 0) == 0) frm[$urandom_range(len - 1, 0)] ^= 8'(1 << $urandom_range(7, 0));
      eq.push_back(exp_frame());
      send_frame(0, 0);
    end
    idle_beat();
    checks++;
    if (n_status != s0 + 16) begin
      errors++; $display("FAIL b2b_pulses: got %0d, want 16", n_status - s0);
    end
    for (int f = 0; f < 16; f++) begin
      checks++;
      if (caps[s0+f] !== eq[f]) begin
        errors++; $display("FAIL b2b_frame%0d: got %h, want %h", f, caps[s0+f], eq[f]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [19:0] e;
    int s0;
    make_frame(70000); e = exp_frame(); s0 = n_status;
    send_frame(0, 0);
    checks++;
    if (n_status != s0 + 1 || caps[caps.size()-1] !== e || frame_len !== 16'hFFFF) begin
      errors++; $display("FAIL saturate: got %h, want %h", caps[caps.size()-1], e);
    end
    idle_beat();
  endtask

  initial begin
    build_tab();
    rst = 1'b1; dready = 1'b0; datain = '0; ctrl_wd = '0; bvalid = '0;
    test_reset();
    test_good_frame();
    test_short_frame();
    test_abort();
    test_bad_bvalid();
    test_ignored();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
